// File: rtl/rc4_s_init_ksa.sv
// RC4 S-array engine: fills S with the identity permutation, then optionally runs
// the key-scheduling swap loop over the same single-port memory.
module rc4_s_init_ksa #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ksa_en,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [ADDR_W-1:0]      s_address,
  output logic [ADDR_W-1:0]      s_data,
  output logic                   s_wren,
  input  logic [ADDR_W-1:0]      s_q,
  output logic                   busy,
  output logic                   done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST = '1;
  localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_RD_I, KSA_WAIT_I, KSA_RD_J, KSA_WAIT_J, KSA_WR_I, KSA_WR_J, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] si;
  logic [KW-1:0]     k;
  logic              ksa_mode;

  // Key byte 0 sits in the most significant byte of the key port.
  logic [7:0] key_bytes [KEY_BYTES];
  generate
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
      assign key_bytes[gi] = key[(KEY_BYTES-gi)*8-1 -: 8];
    end
  endgenerate

  logic [ADDR_W-1:0] key_add;
  logic [ADDR_W-1:0] j_new;
  assign key_add = ADDR_W'(key_bytes[k]);
  assign j_new   = j + s_q + key_add;

  // Outputs are loaded on the edge that enters a state, so each state's
  // memory access is presented during that state's own cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      k         <= '0;
      ksa_mode  <= 1'b0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ksa_mode  <= ksa_en;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            s_address <= '0;
            s_data    <= '0;
            s_wren    <= 1'b1;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          if (i == I_LAST) begin
            i         <= '0;
            s_address <= '0;
            s_data    <= '0;
            s_wren    <= 1'b0;
            if (ksa_mode) begin
              state <= KSA_RD_I;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            i         <= i + 1'b1;
            s_address <= i + 1'b1;
            s_data    <= i + 1'b1;
          end
        end
        KSA_RD_I: state <= KSA_WAIT_I;
        KSA_WAIT_I: begin
          si        <= s_q;
          j         <= j_new;
          s_address <= j_new;
          state     <= KSA_RD_J;
        end
        KSA_RD_J: state <= KSA_WAIT_J;
        KSA_WAIT_J: begin
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= KSA_WR_I;
        end
        KSA_WR_I: begin
          // When i == j this second write lands on the same entry with the same value.
          s_address <= j;
          s_data    <= si;
          state     <= KSA_WR_J;
        end
        KSA_WR_J: begin
          s_wren <= 1'b0;
          s_data <= '0;
          i      <= i + 1'b1;
          k      <= (k == K_LAST) ? '0 : k + 1'b1;
          if (i == I_LAST) begin
            s_address <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            s_address <= i + 1'b1;
            state     <= KSA_RD_I;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_s_init_ksa.sv
// Self-checking bench: a 256-entry engine and a 4-entry engine, each on its own
// behavioural RAM, compared against a plain software KSA model.
module tb_rc4_s_init_ksa;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Large instance: ADDR_W=8, KEY_BYTES=3
  logic        start8, ksa_en8, s_wren8, busy8, done8;
  logic [23:0] key8;
  logic [7:0]  s_address8, s_data8, s_q8, raddr8;
  logic [7:0]  mem8 [256];

  rc4_s_init_ksa #(.ADDR_W(8), .KEY_BYTES(3)) dut (
    .clk(clk), .reset(reset), .start(start8), .ksa_en(ksa_en8), .key(key8),
    .s_address(s_address8), .s_data(s_data8), .s_wren(s_wren8), .s_q(s_q8),
    .busy(busy8), .done(done8)
  );

  always @(posedge clk) begin
    if (s_wren8) mem8[s_address8] <= s_data8;
    raddr8 <= s_address8;
  end
  assign s_q8 = mem8[raddr8];

  // Small instance: ADDR_W=2, KEY_BYTES=2
  logic        start2, ksa_en2, s_wren2, busy2, done2;
  logic [15:0] key2;
  logic [1:0]  s_address2, s_data2, s_q2, raddr2;
  logic [1:0]  mem2 [4];

  rc4_s_init_ksa #(.ADDR_W(2), .KEY_BYTES(2)) dut_s (
    .clk(clk), .reset(reset), .start(start2), .ksa_en(ksa_en2), .key(key2),
    .s_address(s_address2), .s_data(s_data2), .s_wren(s_wren2), .s_q(s_q2),
    .busy(busy2), .done(done2)
  );

  always @(posedge clk) begin
    if (s_wren2) mem2[s_address2] <= s_data2;
    raddr2 <= s_address2;
  end
  assign s_q2 = mem2[raddr2];

  int checks   = 0;
  int failures = 0;
  int ref_s [256];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Textbook RC4 key schedule over an S of 2^aw entries.
  task automatic ref_ksa(input int aw, input int kb, input logic [23:0] kv, input bit en);
    int n, jj, t, kbyte;
    n  = 1 << aw;
    jj = 0;
    for (int x = 0; x < n; x++) ref_s[x] = x;
    if (en) begin
      for (int x = 0; x < n; x++) begin
        kbyte    = int'((kv >> (8 * (kb - 1 - (x % kb)))) & 24'hff);
        jj       = (jj + ref_s[x] + kbyte) % n;
        t        = ref_s[x];
        ref_s[x] = ref_s[jj];
        ref_s[jj] = t;
      end
    end
  endtask

  task automatic run_big(input bit en, input logic [23:0] kv, input bit toggle, input bit hold,
                         input string tag);
    int n, total, writes, bad, done_at, hold_bad, errs;
    bit exp_wr;
    n = 256; total = en ? 7 * n : n;
    writes = 0; bad = 0; done_at = -1; hold_bad = 0; errs = 0;
    @(negedge clk);
    key8 = kv; ksa_en8 = en; start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= total + 20; c++) begin
      @(negedge clk);
      exp_wr = (c <= n) || (en && c <= total && ((c - n - 1) % 6 >= 4));
      if (s_wren8 !== exp_wr) bad++;
      if (c <= n && (s_address8 !== 8'(c - 1) || s_data8 !== 8'(c - 1))) bad++;
      if (busy8 !== (c <= total)) bad++;
      if (s_wren8 === 1'b1) writes++;
      if (c >= total - 5) start8 = hold;
      else if (toggle && c >= 2) start8 = 1'($urandom_range(0, 1));
      if (done8 === 1'b1) begin
        done_at = c;
        break;
      end
    end
    check({tag, "_writes"}, writes, en ? 3 * n : n);
    check({tag, "_pattern"}, bad, 0);
    check({tag, "_done_cycle"}, done_at, total + 1);
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        if (done8 !== 1'b1 || busy8 !== 1'b0 || s_wren8 !== 1'b0) hold_bad++;
      end
      check({tag, "_done_hold"}, hold_bad, 0);
    end
    start8 = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, int'(done8), 0);
    hold_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || s_wren8 !== 1'b0) hold_bad++;
    end
    check({tag, "_no_restart"}, hold_bad, 0);
    ref_ksa(8, 3, kv, en);
    for (int x = 0; x < n; x++) if (mem8[x] !== ref_s[x][7:0]) errs++;
    check({tag, "_sbox"}, errs, 0);
    $display("run %s en=%0d key=%06h done_at=%0d writes=%0d sbox_errs=%0d",
             tag, en, kv, done_at, writes, errs);
  endtask

  task automatic run_small(input logic [15:0] kv, input bit fixed, input logic [7:0] fixed_s,
                           input string tag);
    int done_at, writes, errs;
    logic [7:0] got;
    done_at = -1; writes = 0; errs = 0;
    @(negedge clk);
    key2 = kv; ksa_en2 = 1'b1; start2 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (s_wren2 === 1'b1) writes++;
      if (done2 === 1'b1) begin
        done_at = c;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_at, 29);
    check({tag, "_writes"}, writes, 12);
    ref_ksa(2, 2, {8'h00, kv}, 1'b1);
    for (int x = 0; x < 4; x++) if (mem2[x] !== ref_s[x][1:0]) errs++;
    check({tag, "_sbox"}, errs, 0);
    got = {mem2[0], mem2[1], mem2[2], mem2[3]};
    if (fixed) check({tag, "_sbox_const"}, int'(got), int'(fixed_s));
    $display("run %s key=%04h done_at=%0d S=[%0d,%0d,%0d,%0d]",
             tag, kv, done_at, mem2[0], mem2[1], mem2[2], mem2[3]);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int quiet;
    reset = 1'b1;
    start8 = 1'b0; ksa_en8 = 1'b0; key8 = '0;
    start2 = 1'b0; ksa_en2 = 1'b0; key2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_big", int'({s_address8, s_data8, s_wren8, busy8, done8}), 0);
    check("reset_small", int'({s_address2, s_data2, s_wren2, busy2, done2}), 0);
    reset = 1'b0;

    run_big(1'b0, 24'($urandom), 1'b0, 1'b1, "init_only_hold");
    run_big(1'b1, 24'h000249, 1'b0, 1'b0, "ksa_000249");
    for (int r = 0; r < 3; r++)
      run_big(1'b1, 24'($urandom), 1'b1, 1'($urandom_range(0, 1)), "ksa_rand");

    // Reset while the swap loop is on i=37.
    @(negedge clk);
    key8 = 24'($urandom); ksa_en8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 257 + 37 * 6 + 2; c++) begin
      @(negedge clk);
      if (c == 2) start8 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", int'({s_address8, s_data8, s_wren8, busy8, done8}), 0);
    reset = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_wren8 !== 1'b0 || busy8 !== 1'b0) quiet++;
    end
    check("mid_reset_quiet", quiet, 0);
    run_big(1'b1, key8, 1'b0, 1'b0, "after_reset");

    run_small(16'h0000, 1'b1, {2'd0, 2'd2, 2'd3, 2'd1}, "small_key0000");
    run_small(16'h0101, 1'b1, {2'd0, 2'd2, 2'd3, 2'd1}, "small_key0101");
    for (int r = 0; r < 2; r++)
      run_small(16'($urandom), 1'b0, 8'h00, "small_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_s_init_ksa.md
# rc4_s_init_ksa

Parametrised S-array engine for the RC4 decryption datapath. It first fills the S memory with the identity permutation (S[i] = i). It then optionally runs the RC4 key-scheduling swap loop over the same memory, using a parametrised-length key. It drives the single-port S memory (address, write data, write enable, read data) and signals completion to the top-level controller through a start/done handshake.

## Interface
Parameters:
- ADDR_W, 8: S depth is 2^ADDR_W. Entry width is also ADDR_W.
- KEY_BYTES, 3: number of key bytes, at least 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request, sampled only in IDLE.
- ksa_en  in  1  1 = identity fill then KSA; 0 = identity fill only. Sampled with start.
- key  in  KEY_BYTES*8  key byte 0 = key[KEY_BYTES*8-1 -: 8]. Must stay stable while busy.
- s_address  out  ADDR_W  S memory address.
- s_data  out  ADDR_W  S memory write data.
- s_wren  out  1  S memory write enable.
- s_q  in  ADDR_W  S memory read data; valid the cycle after the address is driven.
- busy  out  1  high from the first INIT cycle through the last write.
- done  out  1  completion flag; held until start is low.

## Operation
- All outputs are registered.
- Reset values: s_address=0, s_data=0, s_wren=0, busy=0, done=0. State=IDLE, i=0, j=0, key index k=0.
- IDLE:
  - Outputs are at their reset values.
  - If start=1, latch ksa_en, clear i, j and k, and go to INIT.
- INIT: each cycle drive s_address=i, s_data=i, s_wren=1, then i++.
  - After the write with i=2^ADDR_W-1: i wraps to 0 and the engine goes to KSA_RD_I if ksa_en=1, otherwise to DONE.
- KSA loop, 6 cycles per i:
  - KSA_RD_I: s_address=i, s_wren=0.
  - KSA_WAIT_I: latch si=s_q. Compute j = (j + si + key_byte[k][ADDR_W-1:0]) mod 2^ADDR_W, registered.
  - KSA_RD_J: s_address=j (new value).
  - KSA_WAIT_J: latch sj=s_q.
  - KSA_WR_I: s_address=i, s_data=sj, s_wren=1.
  - KSA_WR_J: s_address=j, s_data=si, s_wren=1. Then i++ and k = (k==KEY_BYTES-1) ? 0 : k+1. k uses a wrap counter, not a divider.
  - After KSA_WR_J with i=2^ADDR_W-1, go to DONE. Otherwise go to KSA_RD_I.
- Key bytes whose width exceeds ADDR_W are truncated to the low ADDR_W bits. All index arithmetic is modulo 2^ADDR_W.
- i == j: both writes go to the same address. The final value is si, which equals sj, so the entry is unchanged.
- DONE: done=1, busy=0, s_wren=0. When start=0, go to IDLE and clear done on the next edge.
- reset=1 in any state: on that edge the engine returns to IDLE with reset values. Partial memory contents are left as-is. No further write occurs after the reset edge.
- start is ignored outside IDLE.

## Timing
- If start=1 is sampled at edge e0, the first INIT write is presented in the cycle after e0.
- INIT lasts 2^ADDR_W cycles, with one write per cycle.
- The KSA phase lasts 6·2^ADDR_W cycles.
- done rises the cycle after the last write:
  - ksa_en=0: 2^ADDR_W + 1 cycles after e0.
  - ksa_en=1: 7·2^ADDR_W + 1 cycles after e0 (1793 for ADDR_W=8).
- Read latency assumption: an address driven in cycle n appears on s_q in cycle n+1 (address registered by the memory).
- Read-after-write: a write in cycle n is visible to a read addressed in cycle n+1 or later. No bypass is required.
- If start is still high when done is high, the engine stays in DONE. It does not restart until start has gone low and then high again.

## Test plan
- ADDR_W=8, ksa_en=0, start held high. Required: 256 writes with S[i]=i, done after 257 cycles, done stays high, busy low in DONE.
- ADDR_W=2, KEY_BYTES=1, key=8'h01, ksa_en=1. Required: final S = [0,2,3,1], done 29 cycles after the start edge.
- ADDR_W=2, KEY_BYTES=2, key=16'h0000. Required: i=0→j=0 (self-swap), i=1→j=1 (self-swap), i=2→j=3 (swap S2,S3) gives [0,1,3,2]; i=3→j=3+S3(2)=5 mod 4=1 (swap S3,S1) gives [0,2,3,1]. Final S = [0,2,3,1].
- ADDR_W=8, KEY_BYTES=3, key=24'h000249. Compare final S against a software KSA model entry by entry. Check the write pattern repeats every 6 cycles and that k cycles 0,1,2.
- Reset asserted mid-KSA (i=37). Required: outputs reach reset values at that edge, no s_wren afterwards, and a following start re-runs from INIT and produces the model result.
- start toggles while busy, and start is held high through DONE. Required: no restart, and a single run per rising request.
